// File: rtl/egcd_pkg.sv
// Shared types and constants for the extended-Euclid / modular-inverse engine.
// Constant-time build selected by defining EGCD_CONST_TIME_EN.
package egcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DIV  = 3'd2,
    ST_UPD  = 3'd3,
    ST_NORM = 3'd4,
    ST_DONE = 3'd5
  } egcd_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int SW        = DEF_WIDTH + 2;
  localparam int BIT_W     = $clog2(DEF_WIDTH);

  // Worst-case Euclid step count (Fibonacci bound) plus one step for an a<b swap.
  function automatic int max_iter_default(input int w);
    return (3 * w) / 2 + 2;
  endfunction

endpackage

// File: rtl/egcd_if.sv
// Job interface of the extended-Euclid engine: request side (master) and engine side (slave).
// Handshake: start is sampled only while the engine is idle; the sampling edge captures
//   a, b and mode_inv. busy is high from the cycle after that edge until finish. finish is a
//   one-cycle pulse; results hold from the finish cycle until the next accepted start.
//   start during busy, or in the finish cycle, is ignored.
interface egcd_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    mode_inv;
  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic                    busy;
  logic                    finish;
  logic [WIDTH-1:0]        gcd;
  logic signed [WIDTH:0]   s;
  logic signed [WIDTH:0]   t;
  logic [WIDTH-1:0]        inv;
  logic                    inv_ok;
  logic                    err;
  logic [CNT_W-1:0]        cyc_cnt;

  modport master (
    output start, mode_inv, a, b,
    input  busy, finish, gcd, s, t, inv, inv_ok, err, cyc_cnt
  );

  modport slave (
    input  start, mode_inv, a, b,
    output busy, finish, gcd, s, t, inv, inv_ok, err, cyc_cnt
  );
endinterface

// File: rtl/egcd_divstep.sv
// One restoring-division bit slice: conditionally subtracts (r1,s1,t1) << bit from (r0,s0,t0).
// Purely combinational; the caller owns every register.
module egcd_divstep
  import egcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW_W  = WIDTH + 2,
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       i_r0,
  input  logic [WIDTH-1:0]       i_r1,
  input  logic signed [SW_W-1:0] i_s0,
  input  logic signed [SW_W-1:0] i_s1,
  input  logic signed [SW_W-1:0] i_t0,
  input  logic signed [SW_W-1:0] i_t1,
  input  logic [BW-1:0]          i_bit,
  output logic [WIDTH-1:0]       o_r0,
  output logic signed [SW_W-1:0] o_s0,
  output logic signed [SW_W-1:0] o_t0,
  output logic                   o_q
);

  // Double-width shift so a large divisor shifted left never wraps into a false match.
  logic [2*WIDTH-1:0] w_r1_sh;

  assign w_r1_sh = {{WIDTH{1'b0}}, i_r1} << i_bit;
  assign o_q     = ({{WIDTH{1'b0}}, i_r0} >= w_r1_sh);
  assign o_r0    = o_q ? (i_r0 - w_r1_sh[WIDTH-1:0]) : i_r0;
  assign o_s0    = o_q ? (i_s0 - (i_s1 <<< i_bit)) : i_s0;
  assign o_t0    = o_q ? (i_t0 - (i_t1 <<< i_bit)) : i_t0;

endmodule

// File: rtl/egcd_modinv.sv
// Iterative extended-Euclid engine: gcd, Bezout s/t, optional a^-1 mod b, cycle count.
// EGCD_CONST_TIME_EN: pad every job to MAX_ITER division steps for data-independent latency.
module egcd_modinv
  import egcd_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = max_iter_default(WIDTH),
  parameter int CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  egcd_if.slave                          bus,
  output egcd_state_e                    o_dbg_state,
  output logic [$clog2(MAX_ITER+1):0]    o_dbg_step,
  output logic [WIDTH-1:0]               o_dbg_quot
);

  localparam int L_SW   = WIDTH + 2;
  localparam int L_BW   = $clog2(WIDTH);
  localparam int STEP_W = $clog2(MAX_ITER + 1) + 1;

  egcd_state_e             r_state;
  logic [WIDTH-1:0]        r_r0, r_r1, r_b;
  logic signed [L_SW-1:0]  r_s0, r_s1, r_t0, r_t1;
  logic                    r_mode, r_err;
  logic [L_BW-1:0]         r_bit;
  logic [STEP_W-1:0]       r_step;
  logic [WIDTH-1:0]        r_quot;
  logic                    r_busy, r_finish, r_inv_ok, r_err_o;
  logic [WIDTH-1:0]        r_gcd, r_inv;
  logic signed [WIDTH:0]   r_s, r_t;
  logic [CNT_W-1:0]        r_cyc;
`ifdef EGCD_CONST_TIME_EN
  logic                    r_dummy;
`endif

  logic [WIDTH-1:0]        w_r0_nxt;
  logic signed [L_SW-1:0]  w_s0_nxt, w_t0_nxt;
  logic                    w_q, w_live, w_inv_ok;
  logic [STEP_W-1:0]       w_step_inc;
  logic [WIDTH-1:0]        w_s_adj, w_inv;

  egcd_divstep #(.WIDTH(WIDTH), .SW_W(L_SW), .BW(L_BW)) u_divstep (
    .i_r0 (r_r0),
    .i_r1 (r_r1),
    .i_s0 (r_s0),
    .i_s1 (r_s1),
    .i_t0 (r_t0),
    .i_t1 (r_t1),
    .i_bit(r_bit),
    .o_r0 (w_r0_nxt),
    .o_s0 (w_s0_nxt),
    .o_t0 (w_t0_nxt),
    .o_q  (w_q)
  );

`ifdef EGCD_CONST_TIME_EN
  assign w_live = !r_dummy;
`else
  assign w_live = 1'b1;
`endif

  assign w_step_inc = r_step + STEP_W'(1);
  assign w_inv_ok   = r_mode && !r_err && (r_r0 == WIDTH'(1));
  // s lies in (-b, b), so the low WIDTH bits of s+b are already the normalised residue.
  assign w_s_adj    = r_s0[WIDTH-1:0] + r_b;
  assign w_inv      = !w_inv_ok ? '0 : (r_s0[L_SW-1] ? w_s_adj : r_s0[WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_r0     <= '0;
      r_r1     <= '0;
      r_b      <= '0;
      r_s0     <= '0;
      r_s1     <= '0;
      r_t0     <= '0;
      r_t1     <= '0;
      r_mode   <= 1'b0;
      r_err    <= 1'b0;
      r_bit    <= '0;
      r_step   <= '0;
      r_quot   <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_gcd    <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_inv    <= '0;
      r_inv_ok <= 1'b0;
      r_err_o  <= 1'b0;
      r_cyc    <= '0;
`ifdef EGCD_CONST_TIME_EN
      r_dummy  <= 1'b0;
`endif
    end else begin
      r_finish <= 1'b0;
      if (r_busy && (r_cyc != {CNT_W{1'b1}})) r_cyc <= r_cyc + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_r0    <= bus.a;
            r_r1    <= bus.b;
            r_b     <= bus.b;
            r_s0    <= L_SW'(1);
            r_s1    <= '0;
            r_t0    <= '0;
            r_t1    <= L_SW'(1);
            r_mode  <= bus.mode_inv;
            r_err   <= (bus.a == '0) && (bus.b == '0);
            r_step  <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_bit <= L_BW'(WIDTH - 1);
`ifdef EGCD_CONST_TIME_EN
          r_dummy <= (r_r1 == '0);
          r_state <= ST_DIV;
`else
          r_state <= (r_r1 == '0) ? ST_NORM : ST_DIV;
`endif
        end
        ST_DIV: begin
          if (w_live) begin
            r_r0 <= w_r0_nxt;
            r_s0 <= w_s0_nxt;
            r_t0 <= w_t0_nxt;
          end
          r_quot <= {r_quot[WIDTH-2:0], w_q};
          r_bit  <= r_bit - L_BW'(1);
          if (r_bit == '0) r_state <= ST_UPD;
        end
        ST_UPD: begin
          // r0 now holds the remainder: rotate rows so the remainder becomes the new divisor.
          if (w_live) begin
            r_r0 <= r_r1;
            r_s0 <= r_s1;
            r_t0 <= r_t1;
            r_r1 <= r_r0;
            r_s1 <= r_s0;
            r_t1 <= r_t0;
          end
          r_step <= w_step_inc;
          r_bit  <= L_BW'(WIDTH - 1);
`ifdef EGCD_CONST_TIME_EN
          if (w_live && (r_r0 == '0)) r_dummy <= 1'b1;
          r_state <= (w_step_inc == STEP_W'(MAX_ITER)) ? ST_NORM : ST_DIV;
`else
          r_state <= (r_r0 == '0) ? ST_NORM : ST_DIV;
`endif
        end
        ST_NORM: begin
          r_gcd    <= r_err ? '0 : r_r0;
          r_s      <= r_err ? '0 : r_s0[WIDTH:0];
          r_t      <= r_err ? '0 : r_t0[WIDTH:0];
          r_inv    <= w_inv;
          r_inv_ok <= w_inv_ok;
          r_err_o  <= r_err;
          r_busy   <= 1'b0;
          r_finish <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef EGCD_CONST_TIME_EN
  // A live remainder at the last padded step means MAX_ITER is too small for this operand.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ST_UPD) && w_live)
      assert (!((r_r0 != '0) && (w_step_inc == STEP_W'(MAX_ITER))));
  end
`endif

  assign bus.busy    = r_busy;
  assign bus.finish  = r_finish;
  assign bus.gcd     = r_gcd;
  assign bus.s       = r_s;
  assign bus.t       = r_t;
  assign bus.inv     = r_inv;
  assign bus.inv_ok  = r_inv_ok;
  assign bus.err     = r_err_o;
  assign bus.cyc_cnt = r_cyc;

  assign o_dbg_state = r_state;
  assign o_dbg_step  = r_step;
  assign o_dbg_quot  = r_quot;

endmodule

// File: tb/tb_egcd_modinv.sv
// Self-checking bench for egcd_modinv (WIDTH=16); honours EGCD_CONST_TIME_EN for latency.
module tb_egcd_modinv;
  import egcd_pkg::*;

  localparam int W           = 16;
  localparam int TB_MAX_ITER = 26;
  localparam int N_RAND      = 100;

  typedef struct packed {
    logic [W-1:0] a, b, gcd;
    logic [W:0]   s, t;
    logic [W-1:0] inv;
    logic         inv_ok, err;
    logic [15:0]  lat;
    logic [7:0]   steps;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  egcd_state_e  dbg_state;
  logic [5:0]   dbg_step;
  logic [W-1:0] dbg_quot;

  egcd_if #(.WIDTH(W), .CNT_W(16)) bus ();

  egcd_modinv #(.WIDTH(W), .MAX_ITER(TB_MAX_ITER), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state),
    .o_dbg_step (dbg_step),
    .o_dbg_quot (dbg_quot)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: textbook extended Euclid with integer division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t   e;
    longint r0, r1, s0, s1, t0, t1, q, tmp, iv;
    int     n;
    e = '0;
    r0 = longint'(a); r1 = longint'(b);
    s0 = 1; s1 = 0; t0 = 0; t1 = 1; n = 0;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = s0 - q * s1; s0 = s1; s1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      n++;
    end
    e.a = a;
    e.b = b;
    if (a == 0 && b == 0) begin
      e.err = 1'b1;
    end else begin
      e.gcd    = r0[W-1:0];
      e.s      = s0[W:0];
      e.t      = t0[W:0];
      e.inv_ok = m && (r0 == 1);
      iv       = (s0 < 0) ? s0 + longint'(b) : s0;
      e.inv    = e.inv_ok ? iv[W-1:0] : '0;
    end
`ifdef EGCD_CONST_TIME_EN
    e.lat   = 16'(2 + TB_MAX_ITER * (W + 1));
    e.steps = 8'(TB_MAX_ITER);
`else
    e.lat   = 16'(2 + n * (W + 1));
    e.steps = 8'(n);
`endif
    return e;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},    bus.busy,    0);
    check_eq({tag, "_finish"},  bus.finish,  0);
    check_eq({tag, "_gcd"},     bus.gcd,     0);
    check_eq({tag, "_s"},       bus.s,       0);
    check_eq({tag, "_t"},       bus.t,       0);
    check_eq({tag, "_inv"},     bus.inv,     0);
    check_eq({tag, "_inv_ok"},  bus.inv_ok,  0);
    check_eq({tag, "_err"},     bus.err,     0);
    check_eq({tag, "_cyc_cnt"}, bus.cyc_cnt, 0);
    check_eq({tag, "_state"},   dbg_state,   ST_IDLE);
  endtask

  // driver + monitor: one job, optional stray start mid-job or in the finish cycle
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input int poke_at, input bit start_at_finish);
    exp_t   e;
    int     k;
    longint bez;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.mode_inv = m; bus.start = 1'b1;
    exp_q.push_back(model(a, b, m));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.mode_inv = ~m;
    check_eq("busy_after_accept", bus.busy, 1);
    k = 0;
    while (!bus.finish && k < 1000) begin
      if (k == poke_at) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    e = exp_q.pop_front();
    if (!bus.finish) begin
      check_eq("finish_timeout", k, e.lat);
      return;
    end
    check_eq("latency", k, e.lat);
    check_eq("cyc_cnt", bus.cyc_cnt, e.lat);
    check_eq("busy_at_finish", bus.busy, 0);
    check_eq("gcd", bus.gcd, e.gcd);
    check_eq("s", longint'($signed(bus.s)), longint'($signed(e.s)));
    check_eq("t", longint'($signed(bus.t)), longint'($signed(e.t)));
    check_eq("inv", bus.inv, e.inv);
    check_eq("inv_ok", bus.inv_ok, e.inv_ok);
    check_eq("err", bus.err, e.err);
    check_eq("steps", dbg_step, e.steps);
    bez = longint'(e.a) * longint'($signed(bus.s)) + longint'(e.b) * longint'($signed(bus.t));
    check_eq("bezout", bez, e.gcd);
    if (start_at_finish) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("finish_one_cycle", bus.finish, 0);
    check_eq("idle_after_done", bus.busy, 0);
    check_eq("cyc_cnt_hold", bus.cyc_cnt, e.lat);
  endtask

  task automatic reset_mid_job();
    int seen;
    @(negedge clk);
    bus.a = 16'd3016; bus.b = 16'd27; bus.mode_inv = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (38) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.finish) seen++;
    end
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (bus.finish || bus.busy) seen++;
    end
    check_eq("no_finish_after_reset", seen, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.mode_inv = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    run_job(16'd3016, 16'd27,   1'b1, -1, 1'b0);
    run_job(16'd27,   16'd3016, 1'b1, -1, 1'b0);
    run_job(16'd48,   16'd18,   1'b1, -1, 1'b0);
    run_job(16'd5,    16'd0,    1'b0, -1, 1'b0);
    run_job(16'd0,    16'd0,    1'b1, -1, 1'b0);
    run_job(16'd0,    16'd7,    1'b1, -1, 1'b0);
    run_job(16'd1,    16'd1,    1'b1, -1, 1'b0);
    run_job(16'd65535, 16'd65534, 1'b1, -1, 1'b0);
    run_job(16'd46368, 16'd28657, 1'b1, -1, 1'b0);
    run_job(16'd3016, 16'd27,   1'b1, 30, 1'b1);
    run_job(16'd17,   16'd3120, 1'b0, -1, 1'b0);
    reset_mid_job();
    run_job(16'd3016, 16'd27,   1'b1, -1, 1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      run_job(ra, rb, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
